// File: rtl/mix_columns_iter_if.sv
// rtl/mix_columns_iter_if.sv - handshake bundle for the iterative MixColumns engine
interface mix_columns_iter_if #(
    parameter int STATE_W = 128
);
    logic               in_valid;
    logic               in_ready;
    logic [STATE_W-1:0] in_data;
    logic               in_inv;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] out_data;
    logic               busy;

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/mix_columns_iter.sv
// rtl/mix_columns_iter.sv - iterative MixColumns/InvMixColumns engine, COLS_PER_CYCLE columns per clock
module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 4,
    parameter int STATE_W        = 128
) (
    input  logic              clk,
    input  logic              rst,
    mix_columns_iter_if.slave bus
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
    if (STATE_W != 128) begin : g_bad_width
        $error("mix_columns_iter: STATE_W must be 128");
    end

    // Counter walks column indices 0..3; with four columns per cycle it never moves.
    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE % 4);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [STATE_W-1:0] data_q, data_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               inv_q, inv_d;
    logic               in_ready;
    logic               out_valid;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse is a pre-mix with 4*(a0^a2)/4*(a1^a3) followed by the forward mix.
    function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
        logic [7:0] a0, a1, a2, a3, t, u, v;
        a0 = col[7:0];
        a1 = col[15:8];
        a2 = col[23:16];
        a3 = col[31:24];
        if (inv) begin
            u  = xtime(xtime(a0 ^ a2));
            v  = xtime(xtime(a1 ^ a3));
            a0 = a0 ^ u;
            a1 = a1 ^ v;
            a2 = a2 ^ u;
            a3 = a3 ^ v;
        end
        t = a0 ^ a1 ^ a2 ^ a3;
        return {a3 ^ t ^ xtime(a3 ^ a0),
                a2 ^ t ^ xtime(a2 ^ a3),
                a1 ^ t ^ xtime(a1 ^ a2),
                a0 ^ t ^ xtime(a0 ^ a1)};
    endfunction

    logic [1:0]  col_idx [COLS_PER_CYCLE];
    logic [31:0] col_res [COLS_PER_CYCLE];

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign col_idx[g] = cnt_q + 2'(g);
        assign col_res[g] = mix_column(data_q[{col_idx[g], 5'd0} +: 32], inv_q);
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        inv_d     = inv_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    inv_d   = bus.in_inv;
                    cnt_d   = 2'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    data_d[{col_idx[g], 5'd0} +: 32] = col_res[g];
                end
                cnt_d = cnt_q + STEP;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    // Result leaves and the next state may enter on the same edge.
                    in_ready = 1'b1;
                    if (bus.in_valid) begin
                        data_d  = bus.in_data;
                        inv_d   = bus.in_inv;
                        cnt_d   = 2'd0;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, data, counter and mode registers; reset discards any in-flight state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            cnt_q   <= 2'd0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = data_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mix_columns_iter.sv
// tb/tb_mix_columns_iter.sv - randomized self-checking bench for mix_columns_iter at 1, 2 and 4 columns per cycle
module tb_mix_columns_iter;

    logic clk;
    logic rst;

    logic         iv   [3];
    logic [127:0] idat [3];
    logic         iinv [3];
    logic         ordy [3];
    logic         ir   [3];
    logic         ov   [3];
    logic [127:0] od   [3];
    logic         bsy  [3];

    int total;
    int bad;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int CPC = (k == 0) ? 1 : ((k == 1) ? 2 : 4);
        mix_columns_iter_if #(.STATE_W(128)) u_if ();
        assign u_if.in_valid  = iv[k];
        assign u_if.in_data   = idat[k];
        assign u_if.in_inv    = iinv[k];
        assign u_if.out_ready = ordy[k];
        assign ir[k]  = u_if.in_ready;
        assign ov[k]  = u_if.out_valid;
        assign od[k]  = u_if.out_data;
        assign bsy[k] = u_if.busy;
        mix_columns_iter #(.COLS_PER_CYCLE(CPC), .STATE_W(128)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if.slave)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 2 : 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = (a[7]) ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // Circulant matrix product: forward row 0 = 02 03 01 01, inverse row 0 = 0e 0b 0d 09.
    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   cf [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (inv) begin
            cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
        end else begin
            cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(cf[(j - row + 4) % 4], s[c*32 + 8*j +: 8]);
                end
                r[c*32 + 8*row +: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_out(input int k, output int n);
        n = 0;
        while (!ov[k] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ov[k]) n = -1;
    endtask

    task automatic single_txn(input int k, input logic [127:0] d, input logic inv,
                              input logic [127:0] exp, input string name);
        int n;
        iv[k] = 1'b1; idat[k] = d; iinv[k] = inv;
        total++;
        if (ir[k] !== 1'b1) begin
            bad++; $display("FAIL %s k=%0d in_ready got=%b want=1", name, k, ir[k]);
        end
        @(posedge clk); #1;
        iv[k] = 1'b0; idat[k] = rand128(); iinv[k] = ~inv;
        wait_out(k, n);
        total++;
        if (n != lat(k)) begin
            bad++; $display("FAIL %s_latency k=%0d got=%0d want=%0d", name, k, n, lat(k));
        end
        total++;
        if (od[k] !== exp) begin
            bad++; $display("FAIL %s_data k=%0d got=%h want=%h", name, k, od[k], exp);
        end
        total++;
        if (bsy[k] !== 1'b1 || ir[k] !== 1'b0) begin
            bad++; $display("FAIL %s_done_flags k=%0d busy=%b in_ready=%b want busy=1 in_ready=0", name, k, bsy[k], ir[k]);
        end
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
        total++;
        if (ov[k] !== 1'b0 || bsy[k] !== 1'b0) begin
            bad++; $display("FAIL %s_release k=%0d out_valid=%b busy=%b want 0 0", name, k, ov[k], bsy[k]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || bsy[k] !== 1'b0 || od[k] !== 128'h0) begin
                bad++;
                $display("FAIL reset k=%0d in_ready=%b out_valid=%b busy=%b out_data=%h want 1 0 0 0",
                         k, ir[k], ov[k], bsy[k], od[k]);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_known_vectors();
        for (int k = 0; k < 3; k++) begin
            single_txn(k, 128'h4c31262d_01010101_5c220af2_455313db, 1'b0,
                       128'hf8bd7e4d_01010101_9d58dc9f_bca14d8e, "fwd_vec");
            single_txn(k, 128'hf8bd7e4d_01010101_9d58dc9f_bca14d8e, 1'b1,
                       128'h4c31262d_01010101_5c220af2_455313db, "inv_vec");
        end
    endtask

    task automatic test_identity();
        for (int k = 0; k < 3; k++) begin
            single_txn(k, {16{8'hc6}}, 1'b0, {16{8'hc6}}, "c6_fwd");
            single_txn(k, {16{8'hc6}}, 1'b1, {16{8'hc6}}, "c6_inv");
            single_txn(k, 128'h0, 1'b0, 128'h0, "zero_fwd");
            single_txn(k, 128'h0, 1'b1, 128'h0, "zero_inv");
        end
    endtask

    task automatic test_backpressure(input int k);
        logic [127:0] d1, d2, e1, e2;
        logic         m1, m2;
        int           n;
        d1 = rand128(); m1 = 1'($urandom);
        d2 = rand128(); m2 = ~m1;
        e1 = ref_mix(d1, m1);
        e2 = ref_mix(d2, m2);
        iv[k] = 1'b1; idat[k] = d1; iinv[k] = m1;
        @(posedge clk); #1;
        iv[k] = 1'b0;
        wait_out(k, n);
        total++;
        if (n != lat(k)) begin
            bad++; $display("FAIL bp_latency1 k=%0d got=%0d want=%0d", k, n, lat(k));
        end
        for (int c = 0; c < 5; c++) begin
            idat[k] = rand128(); iinv[k] = 1'($urandom);
            iv[k] = 1'($urandom);
            #1;
            total++;
            if (ov[k] !== 1'b1 || ir[k] !== 1'b0 || od[k] !== e1) begin
                bad++;
                $display("FAIL bp_hold k=%0d cyc=%0d out_valid=%b in_ready=%b data=%h want 1 0 %h",
                         k, c, ov[k], ir[k], od[k], e1);
            end
            @(posedge clk); #1;
        end
        iv[k] = 1'b1; idat[k] = d2; iinv[k] = m2; ordy[k] = 1'b1;
        #1;
        total++;
        if (ir[k] !== 1'b1) begin
            bad++; $display("FAIL bp_handoff_ready k=%0d got=%b want=1", k, ir[k]);
        end
        @(posedge clk); #1;
        iv[k] = 1'b0; ordy[k] = 1'b0;
        wait_out(k, n);
        total++;
        if (n != lat(k) || od[k] !== e2) begin
            bad++; $display("FAIL bp_second k=%0d latency=%0d data=%h want %0d %h", k, n, od[k], lat(k), e2);
        end
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
    endtask

    task automatic test_back_to_back(input int k);
        logic [127:0] exp_q [$];
        int           acc_q [$];
        logic [127:0] e;
        int           a, edge_n, sent, got;
        logic         acc_now;
        edge_n = 0; sent = 0; got = 0;
        ordy[k] = 1'b1;
        iv[k] = 1'b1; idat[k] = rand128(); iinv[k] = 1'b0;
        while (got < 16 && edge_n < 400) begin
            if (ov[k]) begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                total++;
                if (od[k] !== e || (edge_n - a) != lat(k)) begin
                    bad++;
                    $display("FAIL b2b k=%0d idx=%0d data=%h latency=%0d want %h %0d",
                             k, got, od[k], edge_n - a, e, lat(k));
                end
                got++;
            end
            acc_now = iv[k] && ir[k];
            if (acc_now) begin
                exp_q.push_back(ref_mix(idat[k], iinv[k]));
                acc_q.push_back(edge_n + 1);
                sent++;
            end
            @(posedge clk); #1;
            edge_n++;
            if (acc_now) begin
                if (sent < 16) begin
                    idat[k] = rand128(); iinv[k] = 1'(sent % 2);
                end else begin
                    iv[k] = 1'b0;
                end
            end
        end
        total++;
        if (got != 16) begin
            bad++; $display("FAIL b2b_count k=%0d got=%0d want=16", k, got);
        end
        iv[k] = 1'b0;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
        total++;
        if (bsy[k] !== 1'b0) begin
            bad++; $display("FAIL b2b_idle k=%0d busy=%b want=0", k, bsy[k]);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] d;
        logic         seen;
        d = rand128();
        iv[0] = 1'b1; idat[0] = d; iinv[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || od[0] !== 128'h0 || bsy[0] !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset out_valid=%b in_ready=%b out_data=%h busy=%b want 0 1 0 0",
                     ov[0], ir[0], od[0], bsy[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ov[0]) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL mid_reset_no_output got out_valid=1 want none");
        end
        d = rand128();
        single_txn(0, d, 1'b1, ref_mix(d, 1'b1), "after_reset");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; idat[k] = '0; iinv[k] = 1'b0; ordy[k] = 1'b0;
        end
        test_reset();
        test_known_vectors();
        test_identity();
        for (int k = 0; k < 3; k++) test_backpressure(k);
        for (int k = 0; k < 3; k++) test_back_to_back(k);
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
